// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the iterative multiply/divide
// unit.
//   state_e               FSM state encoding (IDLE, MUL, DIV, DONE)
//   MULTDIV_WIDTH_DEFAULT default operand/result width
//   cnt_width()           iteration counter width, log2(width)+1 bits
package multdiv_pkg;

  localparam int MULTDIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/multdiv_div_step.sv
// div_step: one restoring-divide iteration on unsigned magnitudes.
//
// The dividend is shifted into the partial remainder one bit at a time, MSB
// first, out of the top of the quotient register. The low end of the
// quotient register collects the new quotient bit.
//
// Ports:
//   rem_i / rem_o       partial remainder, before and after this step
//   quo_i / quo_o       dividend/quotient shift register, before and after
//   divisor_i           divisor magnitude
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;

  assign rem_shift = {rem_i, quo_i[WIDTH-1]};
  // rem_i < divisor, so rem_shift < 2*divisor and the difference always fits
  // in WIDTH+1 signed bits; the top bit is therefore a true borrow.
  assign trial     = rem_shift - {1'b0, divisor_i};
  assign rem_o     = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_o     = {quo_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply (radix-2 Booth) / signed divide
// (restoring) for the execute stage. One iteration per clock, WIDTH
// iterations per operation, result registered in DONE with a one-cycle
// data_resultRDY strobe.
//
// Ports:
//   clock, reset               clock; asynchronous active-low reset
//   ctrl_MULT, ctrl_DIV        one-cycle start pulses (MULT wins if both)
//   data_operandA/B            operands, sampled only on the start edge
//   data_result                result, held until overwritten
//   data_exception             overflow / divide-by-zero, valid with result
//   data_resultRDY             one-cycle result-valid strobe
//   busy                       operation in flight (drives pipeline stall)
//
// Build option: MULTDIV_EARLY_DIV0_EN short-circuits a divide by zero
// straight to DONE at the start edge instead of running all iterations.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation in flight
// MUL   | Booth iterations, one per edge
// DIV   | restoring-divide iterations, one quotient bit per edge
// DONE  | register result/exception, pulse data_resultRDY, back to IDLE
module multdiv_unit import multdiv_pkg::*; #(
  parameter int WIDTH = MULTDIV_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [2*WIDTH:0]    prod_q;    // {product_hi, product_lo, q-1}
  logic [WIDTH-1:0]    opr_q;     // multiplicand, or divisor magnitude
  logic [WIDTH-1:0]    rem_q;
  logic [WIDTH-1:0]    quo_q;
  logic                is_div_q;
  logic                neg_q;
  logic                div0_q;
  logic                ovf_q;
  logic [WIDTH-1:0]    result_q;
  logic                exc_q;
  logic                rdy_q;
  logic                busy_q;

  logic [WIDTH-1:0]    a_mag;
  logic [WIDTH-1:0]    b_mag;
  logic [WIDTH:0]      booth_hi_ext;
  logic [WIDTH:0]      booth_m_ext;
  logic [WIDTH:0]      booth_sum;
  logic [2*WIDTH:0]    booth_next;
  logic [WIDTH-1:0]    rem_nx;
  logic [WIDTH-1:0]    quo_nx;
  logic                last_iter;

  assign a_mag = data_operandA[WIDTH-1] ? (-data_operandA) : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? (-data_operandB) : data_operandB;

  // The add/subtract is done one bit wider than product_hi so that
  // subtracting the most negative multiplicand cannot lose its sign; the
  // extra bit is consumed by the arithmetic shift, keeping the stored
  // register at 2*WIDTH+1 bits.
  assign booth_hi_ext = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
  assign booth_m_ext  = {opr_q[WIDTH-1], opr_q};

  always_comb begin
    booth_sum = booth_hi_ext;
    case (prod_q[1:0])
      2'b01:   booth_sum = booth_hi_ext + booth_m_ext;
      2'b10:   booth_sum = booth_hi_ext - booth_m_ext;
      default: booth_sum = booth_hi_ext;
    endcase
  end

  assign booth_next = {booth_sum, prod_q[WIDTH:1]};
  assign last_iter  = (cnt_q == CW'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (opr_q),
    .rem_o     (rem_nx),
    .quo_o     (quo_nx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      opr_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (ctrl_MULT) begin
        // A start in any state restarts; an aborted operation never pulses RDY.
        state_q  <= MUL;
        cnt_q    <= '0;
        opr_q    <= data_operandA;
        prod_q   <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
        is_div_q <= 1'b0;
        busy_q   <= 1'b1;
      end else if (ctrl_DIV) begin
        cnt_q    <= '0;
        opr_q    <= b_mag;
        rem_q    <= '0;
        quo_q    <= a_mag;
        is_div_q <= 1'b1;
        neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div0_q   <= (data_operandB == '0);
        ovf_q    <= (data_operandA == MOST_NEG) && (data_operandB == '1);
        busy_q   <= 1'b1;
`ifdef MULTDIV_EARLY_DIV0_EN
        state_q  <= (data_operandB == '0) ? DONE : DIV;
`else
        state_q  <= DIV;
`endif
      end else begin
        case (state_q)
          MUL: begin
            prod_q <= booth_next;
            if (last_iter) state_q <= DONE;
            else           cnt_q   <= cnt_q + CW'(1);
          end
          DIV: begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            if (last_iter) state_q <= DONE;
            else           cnt_q   <= cnt_q + CW'(1);
          end
          DONE: begin
            if (!is_div_q) begin
              result_q <= prod_q[WIDTH:1];
              exc_q    <= (prod_q[2*WIDTH:WIDTH+1] != {WIDTH{prod_q[WIDTH]}});
            end else if (div0_q) begin
              result_q <= '0;
              exc_q    <= 1'b1;
            end else if (ovf_q) begin
              result_q <= MOST_NEG;
              exc_q    <= 1'b1;
            end else begin
              result_q <= neg_q ? (-quo_q) : quo_q;
              exc_q    <= 1'b0;
            end
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed-vector bench for multdiv_unit (WIDTH=32) with
// hand-computed expected results, latencies and strobe behaviour.
module tb_multdiv_unit;

  logic        clk;
  logic        rst_n;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;
  logic        exc;
  logic        rdy;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef MULTDIV_EARLY_DIV0_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 33;
`endif

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clk),
    .reset          (rst_n),
    .ctrl_MULT      (ctrl_mult),
    .ctrl_DIV       (ctrl_div),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .data_result    (result),
    .data_exception (exc),
    .data_resultRDY (rdy),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Pulse a start, then scrambles the operands to show they are not re-read.
  task automatic start_op(input bit is_mul, input logic [31:0] a,
                          input logic [31:0] b);
    op_a      = a;
    op_b      = b;
    ctrl_mult = is_mul;
    ctrl_div  = ~is_mul;
    @(posedge clk);
    #1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    op_a      = 32'hDEAD_BEEF;
    op_b      = 32'h1234_5678;
  endtask

  task automatic run_op(input string tag, input bit is_mul,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc,
                        input int exp_lat);
    int  lat;
    bit  busy_drop;
    lat       = 0;
    busy_drop = 1'b0;
    start_op(is_mul, a, b);
    check_val($sformatf("%s_busy_start", tag), 32'(busy), 32'd1);
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (rdy) begin
        lat = i;
        break;
      end
      if (!busy) busy_drop = 1'b1;
    end
    check_val($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
    check_val($sformatf("%s_result", tag), result, exp_res);
    check_val($sformatf("%s_exc", tag), 32'(exc), 32'(exp_exc));
    check_val($sformatf("%s_busy_rdy", tag), 32'(busy), 32'd0);
    check_val($sformatf("%s_busy_gap", tag), 32'(busy_drop), 32'd0);
    @(posedge clk);
    #1;
    check_val($sformatf("%s_rdy_pulse", tag), 32'(rdy), 32'd0);
  endtask

  initial begin
    int rdy_seen;
    rst_n     = 1'b0;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_result", result, 32'd0);
    check_val("rst_exc", 32'(exc), 32'd0);
    check_val("rst_rdy", 32'(rdy), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mul_6x7",      1'b1, 32'd6,          32'd7,          32'd42,         1'b0, 33);
    run_op("mul_m5x3",     1'b1, 32'hFFFF_FFFB,  32'd3,          32'hFFFF_FFF1,  1'b0, 33);
    run_op("mul_ovf",      1'b1, 32'h4000_0000,  32'd4,          32'h0000_0000,  1'b1, 33);
    run_op("div_100_7",    1'b0, 32'd100,        32'd7,          32'd14,         1'b0, 33);
    run_op("div_m100_7",   1'b0, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0, 33);
    run_op("div_7_m2",     1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, 33);
    run_op("div_min_m1",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 33);
    run_op("div_by_zero",  1'b0, 32'd5,          32'd0,          32'd0,          1'b1, DIV0_LAT);

    // Restart: multiply aborted by a divide started ten cycles later.
    rdy_seen = 0;
    start_op(1'b1, 32'd3, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
      if (rdy) rdy_seen++;
    end
    check_val("restart_no_early_rdy", 32'(rdy_seen), 32'd0);
    run_op("restart_div", 1'b0, 32'd20, 32'd4, 32'd5, 1'b0, 33);

    // Leaves a non-zero result and a set exception ahead of the reset test.
    run_op("mul_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);

    // Reset in the middle of a multiply.
    start_op(1'b1, 32'd6, 32'd7);
    repeat (16) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_result", result, 32'd0);
    check_val("midrst_exc", 32'(exc), 32'd0);
    check_val("midrst_rdy", 32'(rdy), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (rdy) rdy_seen++;
    end
    check_val("midrst_no_rdy", 32'(rdy_seen), 32'd0);
    check_val("midrst_busy_after", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
